// File: rtl/ps_pkg.sv
// ---------------------------------------------------------------------------
// ps_pkg
// Shared definitions for the paralelo_serial byte serializer:
//   COM_SYM_DEFAULT : default comma/idle symbol
//   BIT_CNT_W       : width of the bit-position counter (8 bits per frame)
//   CNT_LAST        : counter value of the last bit in a frame
//   load_src_e      : where the shift register is reloaded from at a frame
//                     boundary
// ---------------------------------------------------------------------------
package ps_pkg;

    localparam logic [7:0] COM_SYM_DEFAULT = 8'hBC;
    localparam int         BIT_CNT_W       = 3;
    localparam logic [BIT_CNT_W-1:0] CNT_LAST = 3'd7;

    typedef enum logic [1:0] {
        SRC_BUF,
        SRC_BYPASS,
        SRC_IDLE
    } load_src_e;

endpackage

// File: rtl/ps_hold_buf.sv
// ---------------------------------------------------------------------------
// ps_hold_buf
// One-entry holding buffer between the parallel input and the serializer.
// A write always wins over a pop in the same cycle, so a simultaneous
// pop + write replaces the entry and the buffer stays full.
//   clk    : clock
//   srst   : synchronous active-high reset (empties the buffer)
//   write  : store wdata, set full
//   wdata  : byte to store
//   pop    : entry consumed; clears full unless write is also high
//   full   : buffer holds a byte
//   rdata  : stored byte
// ---------------------------------------------------------------------------
module ps_hold_buf (
    input  logic       clk,
    input  logic       srst,
    input  logic       write,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic       full,
    output logic [7:0] rdata
);

    logic       full_q, full_d;
    logic [7:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (write) begin
            full_d = 1'b1;
            data_d = wdata;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            full_q <= 1'b0;
            data_q <= 8'h00;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full  = full_q;
    assign rdata = data_q;

endmodule

// File: rtl/paralelo_serial.sv
// ---------------------------------------------------------------------------
// paralelo_serial
// Serializes bytes into back-to-back 8-bit frames, MSB first, one bit per
// clk_32f cycle. Accepted bytes go either straight into the shift register
// (bypass at a frame boundary) or into a one-entry holding buffer. When no
// byte is available an idle frame is sent.
//
// Build option: define PS_IDLE_COM_EN to send COM_SYM in idle frames;
// otherwise idle frames carry 8'h00.
//
// Ports:
//   clk_32f   : bit-rate clock
//   reset     : synchronous active-high reset
//   data_in   : parallel byte
//   valid_in  : data_in valid
//   ready_out : block can take data_in this cycle
//   data_out  : serial bit stream, MSB first
//   valid_out : current frame carries accepted data
//   byte_sync : pulse on the first bit of each frame
// ---------------------------------------------------------------------------
module paralelo_serial
    import ps_pkg::*;
#(
    parameter logic [7:0] COM_SYM = COM_SYM_DEFAULT
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       valid_out,
    output logic       byte_sync
);

`ifdef PS_IDLE_COM_EN
    localparam logic [7:0] IDLE_SYM = COM_SYM;
`else
    // Zero idle pattern; COM_SYM is masked rather than dropped so the
    // parameter keeps a reference in this build.
    localparam logic [7:0] IDLE_SYM = COM_SYM & 8'h00;
`endif

    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic                 valid_q, valid_d;

    logic       buf_full;
    logic [7:0] buf_data;
    logic       buf_write;
    logic       buf_pop;
    logic       frame_end;
    logic       accept;
    load_src_e  load_src;

    ps_hold_buf u_hold_buf (
        .clk   (clk_32f),
        .srst  (reset),
        .write (buf_write),
        .wdata (data_in),
        .pop   (buf_pop),
        .full  (buf_full),
        .rdata (buf_data)
    );

    always_comb begin
        frame_end = (cnt_q == CNT_LAST);
        // At a frame boundary the buffered byte leaves, so a new one can
        // always be taken there even when the buffer is full.
        ready_out = !reset && (!buf_full || frame_end);
        accept    = valid_in && ready_out;

        if (buf_full) begin
            load_src = SRC_BUF;
        end else if (accept) begin
            load_src = SRC_BYPASS;
        end else begin
            load_src = SRC_IDLE;
        end

        buf_pop   = frame_end && buf_full;
        // A bypassed byte goes straight to the shift register, not the buffer.
        buf_write = accept && !(frame_end && !buf_full);

        cnt_d   = cnt_q + BIT_CNT_W'(1);
        shift_d = {shift_q[6:0], 1'b0};
        valid_d = valid_q;

        if (frame_end) begin
            case (load_src)
                SRC_BUF:    shift_d = buf_data;
                SRC_BYPASS: shift_d = data_in;
                default:    shift_d = IDLE_SYM;
            endcase
            valid_d = (load_src != SRC_IDLE);
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            cnt_q   <= CNT_LAST;
            shift_q <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = shift_q[7];
    assign valid_out = valid_q;
    // cnt sits at its last value during reset, so no pulse is produced then.
    assign byte_sync = (cnt_q == '0);

endmodule

// File: tb/tb_paralelo_serial.sv
// ---------------------------------------------------------------------------
// tb_paralelo_serial
// Self-checking bench for paralelo_serial. A monitor rebuilds each frame
// from data_out using byte_sync, and compares data frames against a
// scoreboard of accepted bytes and idle frames against the idle pattern.
// ---------------------------------------------------------------------------
module tb_paralelo_serial;

`ifdef PS_IDLE_COM_EN
    localparam logic [7:0] IDLE = 8'hBC;
`else
    localparam logic [7:0] IDLE = 8'h00;
`endif

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic       data_out;
    logic       valid_out;
    logic       byte_sync;

    paralelo_serial dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .byte_sync (byte_sync)
    );

    always #5 clk_32f = ~clk_32f;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] sb_q[$];
    logic [8:0] frame_log[$];   // {valid, byte}

    int         mon_idx = -1;
    logic       mon_fv  = 1'b0;
    logic [7:0] mon_acc = 8'h00;

    typedef struct {
        logic [7:0] din;
        int         gap;
        logic [7:0] exp_frame;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk_32f) begin
        #1;
        if (reset) begin
            check("reset_outputs", {28'd0, data_out, valid_out, byte_sync, ready_out}, 32'd0);
            mon_idx = -1;
            sb_q.delete();
        end else begin
            if (byte_sync) begin
                if (mon_idx != -1) check("sync_period", mon_idx, 7);
                mon_idx = 0;
                mon_acc = {7'b0, data_out};
                mon_fv  = valid_out;
            end else if (mon_idx >= 0 && mon_idx < 7) begin
                mon_idx++;
                mon_acc = {mon_acc[6:0], data_out};
                check("valid_steady", {31'd0, valid_out}, {31'd0, mon_fv});
            end else begin
                check("sync_missing", {31'd0, byte_sync}, 32'd1);
                mon_idx = -1;
            end
            if (mon_idx == 7) begin
                frame_log.push_back({mon_fv, mon_acc});
                $display("frame %02h valid=%0b", mon_acc, mon_fv);
                if (mon_fv) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_frame: got %02h expected no data frame", mon_acc);
                    end else begin
                        check("data_frame", {24'd0, mon_acc}, {24'd0, sb_q.pop_front()});
                    end
                end else begin
                    check("idle_frame", {24'd0, mon_acc}, {24'd0, IDLE});
                end
            end
        end
    end

    // ---------------- driver helpers (called positioned at a negedge) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            valid_in = 1'b0;
            @(negedge clk_32f);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] exp, input bit chk_full);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            valid_in = 1'b1;
            data_in  = d;
            #1;
            if (chk_full) check("ready_when_full", {31'd0, ready_out}, {31'd0, (mon_idx == 7)});
            acc = ready_out;
            if (acc) begin
                sb_q.push_back(exp);
                $display("accept %02h", d);
            end
            @(negedge clk_32f);
        end
        if (!acc) begin
            n_checks++;
            $display("FAIL send_timeout: got no accept expected accept of %02h", d);
        end
    endtask

    task automatic wait_idx(input int target, input bit need_fv);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            valid_in = 1'b0;
            if (mon_idx == target && (!need_fv || mon_fv)) found = 1'b1;
            else @(negedge clk_32f);
        end
        if (!found) begin
            n_checks++;
            $display("FAIL wait_timeout: got idx %0d expected idx %0d", mon_idx, target);
        end
    endtask

    task automatic check_log(input string name, input int pos, input logic [8:0] exp);
        if (frame_log.size() <= pos) begin
            n_checks++;
            $display("FAIL %s: got %0d frames expected more than %0d", name, frame_log.size(), pos);
        end else begin
            check(name, {23'd0, frame_log[pos]}, {23'd0, exp});
        end
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[6];

    initial begin
        int n0;
        vecs[0] = '{din: 8'h3C, gap: 0,  exp_frame: 8'h3C};
        vecs[1] = '{din: 8'h00, gap: 3,  exp_frame: 8'h00};
        vecs[2] = '{din: 8'hFF, gap: 10, exp_frame: 8'hFF};
        vecs[3] = '{din: 8'h81, gap: 1,  exp_frame: 8'h81};
        vecs[4] = '{din: 8'h7E, gap: 20, exp_frame: 8'h7E};
        vecs[5] = '{din: 8'h01, gap: 0,  exp_frame: 8'h01};

        // Reset for 3 cycles, then idle frames
        reset = 1'b1;
        repeat (3) @(posedge clk_32f);
        @(negedge clk_32f);
        reset = 1'b0;
        idle(26);

        // Single byte presented in the last-bit cycle: bypass, next frame
        wait_idx(7, 0);
        n0 = frame_log.size();
        send(8'hA5, 8'hA5, 0);
        idle(17);
        check_log("a5_latency", n0, {1'b1, 8'hA5});
        check_log("a5_then_idle", n0 + 1, {1'b0, IDLE});

        // Valid held high with three bytes: contiguous frames
        wait_idx(2, 0);
        n0 = frame_log.size();
        send(8'h11, 8'h11, 0);
        send(8'h22, 8'h22, 1);
        send(8'h33, 8'h33, 1);
        idle(40);
        check_log("burst_0", n0 + 1, {1'b1, 8'h11});
        check_log("burst_1", n0 + 2, {1'b1, 8'h22});
        check_log("burst_2", n0 + 3, {1'b1, 8'h33});

        // Table-driven vectors
        foreach (vecs[i]) begin
            idle(vecs[i].gap);
            send(vecs[i].din, vecs[i].exp_frame, 0);
        end
        idle(40);
        check("drain_table", sb_q.size(), 0);

        // Reset mid data frame with a byte buffered
        wait_idx(2, 0);
        send(8'h5A, 8'h5A, 0);
        wait_idx(0, 1);
        send(8'hC3, 8'hC3, 0);
        wait_idx(3, 1);
        reset = 1'b1;
        #1;
        check("ready_in_reset", {31'd0, ready_out}, 32'd0);
        @(negedge clk_32f);
        @(negedge clk_32f);
        reset = 1'b0;
        n0 = frame_log.size();
        idle(20);
        check_log("post_reset_idle0", n0, {1'b0, IDLE});
        check_log("post_reset_idle1", n0 + 1, {1'b0, IDLE});
        check("drain_final", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
